// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// default operand width, product width, counter width and FSM encoding.
package seq_mult_pkg;

    localparam int WIDTH  = 16;
    localparam int PROD_W = 2 * WIDTH;
    // Must satisfy 2**CNT_W > WIDTH so the last iteration index is representable.
    localparam int CNT_W  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : seq_mult_pkg

// File: rtl/add_nbit.sv
// Parameterised N-bit ripple-carry adder with carry-in and carry-out.
// Used by seq_mult16 for the acc + mcand accumulation step.
module add_nbit #(
    parameter int N = 32
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic [N-1:0] o_sum,
    output logic         o_cout
);

    logic [N:0] w_carry;

    assign w_carry[0] = i_cin;

    // One full-adder cell per bit; carry ripples from bit 0 upward.
    for (genvar i = 0; i < N; i++) begin : g_bit
        assign o_sum[i]     = i_a[i] ^ i_b[i] ^ w_carry[i];
        assign w_carry[i+1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
    end

    assign o_cout = w_carry[N];

endmodule : add_nbit

// File: rtl/seq_mult16.sv
// Sequential unsigned shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// One operand pair in flight; valid/ready handshakes on both sides.
// Optional build macro SEQ_MULT16_EARLY_TERM_EN: leave RUN as soon as the
// remaining multiplier bits are all zero (product value is unchanged).
module seq_mult16
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = seq_mult_pkg::WIDTH,
    parameter int CNT_W = seq_mult_pkg::CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int P_W = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [P_W-1:0]     r_acc;
    logic [P_W-1:0]     r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CNT_W-1:0]   r_cnt;
    logic [P_W-1:0]     r_product;

    logic [P_W-1:0]     w_sum;
    logic               w_cout;
    logic [P_W-1:0]     w_acc_next;
    logic [WIDTH-1:0]   w_mplier_next;
    logic               w_last;

    add_nbit #(.N(P_W)) u_add (
        .i_a    (r_acc),
        .i_b    (r_mcand),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    assign w_acc_next    = r_mplier[0] ? w_sum : r_acc;
    assign w_mplier_next = r_mplier >> 1;

`ifdef SEQ_MULT16_EARLY_TERM_EN
    assign w_last = (w_mplier_next == '0) || (r_cnt == LAST_CNT);
`else
    assign w_last = (r_cnt == LAST_CNT);
`endif

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state decode and handshake outputs, all derived from registered state.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        product      = r_product;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) w_state_next = RUN;
            end
            RUN: begin
                if (w_last) w_state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath: load operands on accept, one add/shift step per RUN cycle,
    // capture the final sum into the product register on the exit edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: every datapath register is cleared so no stale partial result survives a reset.
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_acc    <= '0;
                        r_mcand  <= {{WIDTH{1'b0}}, a};
                        r_mplier <= b;
                        r_cnt    <= '0;
                    end
                end
                RUN: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplier_next;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) r_product <= w_acc_next;
                end
                default: ;
            endcase
        end
    end

    // The partial sum can never exceed 2*WIDTH bits while iterating.
    a_no_carry_out : assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == RUN) |-> !w_cout);

endmodule : seq_mult16

// File: tb/tb_seq_mult16.sv
// Self-checking bench for seq_mult16: scoreboard of expected products,
// latency, hold-while-stalled, ignored mid-run requests and mid-run reset.
module tb_seq_mult16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] sb_q[$];

    seq_mult16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Expected number of RUN edges for a given multiplier.
    function automatic int exp_lat(input logic [15:0] mb);
`ifdef SEQ_MULT16_EARLY_TERM_EN
        int hi = 0;
        for (int i = 0; i < 16; i++) if (mb[i]) hi = i;
        return hi + 1;
`else
        return 16;
`endif
    endfunction

    // One transaction. hold: cycles out_ready stays low after out_valid.
    // inject_at / reset_at: RUN cycle index at which to pulse a stray
    // request or a reset (-1 = never).
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_,
                          input int hold, input int inject_at, input int reset_at);
        int k;
        int lat;
        logic [31:0] exp_p;
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        a = ta; b = tb_; in_valid = 1'b1;
        @(posedge clk);
        sb_q.push_back({16'h0, ta} * {16'h0, tb_});
        lat = exp_lat(tb_);
        @(negedge clk);
        in_valid = 1'b0; a = '0; b = '0;
        if (hold > 0) out_ready = 1'b0;
        k = 0;
        while (!out_valid && k < 40) begin
            check("run_flags", {in_ready, busy, out_valid}, 3'b010);
            if (k == inject_at) begin in_valid = 1'b1; a = 16'd7; b = 16'd7; end
            else begin in_valid = 1'b0; a = '0; b = '0; end
            rst_n = (k == reset_at) ? 1'b0 : 1'b1;
            @(posedge clk);
            k++;
            @(negedge clk);
            in_valid = 1'b0;
            if (reset_at >= 0 && k == reset_at + 1) begin
                rst_n = 1'b1;
                check("rst_in_ready", in_ready, 1);
                check("rst_out_valid", out_valid, 0);
                check("rst_busy", busy, 0);
                check("rst_product", product, 0);
                void'(sb_q.pop_front());
                out_ready = 1'b1;
                return;
            end
        end
        check("latency", k, lat);
        exp_p = sb_q.pop_front();
        if (!out_valid) begin
            // Recover from a hung DUT so the run still reaches its summary.
            rst_n = 1'b0; out_ready = 1'b1;
            @(posedge clk); @(negedge clk);
            rst_n = 1'b1;
            return;
        end
        check("product", product, exp_p);
        check("done_flags", {in_ready, busy}, 2'b01);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); @(negedge clk);
            check("hold_product", product, exp_p);
            check("hold_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        check("post_in_ready", in_ready, 1);
        check("post_out_valid", out_valid, 0);
        check("retain_product", product, exp_p);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_flags", {in_ready, out_valid, busy}, 3'b100);
        check("reset_product", product, 0);
        rst_n = 1'b1;

        run_op(16'd3, 16'd5, 0, -1, -1);
        run_op(16'hFFFF, 16'hFFFF, 0, -1, -1);
        run_op(16'h1234, 16'h0100, 5, -1, -1);
        run_op(16'h00AB, 16'h0033, 0, 3, -1);
        run_op(16'd7, 16'd7, 0, -1, -1);
        run_op(16'h0055, 16'h8001, 0, -1, 7);
        run_op(16'd2, 16'd9, 0, -1, -1);
        run_op(16'd10, 16'h0004, 0, -1, -1);
        run_op(16'h9999, 16'h0000, 0, -1, -1);
        run_op(16'h0001, 16'h8000, 2, -1, -1);
        for (int i = 0; i < 4; i++) begin
            run_op(16'($urandom), 16'($urandom), i, -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_seq_mult16
